// File: rtl/fx_bus_arb_pkg.sv
// Shared widths, FSM state type and slice helpers for the fx bus arbiter.
package fx_pkg;

  localparam int FX_AW = 16;
  localparam int FX_DW = 8;
  localparam int MAX_M = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } fx_state_e;

  // Callers zero-extend their packed per-requester vector to MAX_M slices.
  function automatic logic [FX_AW-1:0] fx_addr_slice(input logic [MAX_M*FX_AW-1:0] vec,
                                                     input int unsigned idx);
    return vec[idx*FX_AW +: FX_AW];
  endfunction

  function automatic logic [FX_DW-1:0] fx_data_slice(input logic [MAX_M*FX_DW-1:0] vec,
                                                     input int unsigned idx);
    return vec[idx*FX_DW +: FX_DW];
  endfunction

endpackage

// File: rtl/fx_bus_arb_if.sv
// Requester and fx bus signals of the arbiter.
// slave  : the arbiter's view (takes requests, drives the fx bus strobes).
// master : the requesters' and fx register slave's view.
interface fx_bus_arb_if #(
  parameter int NUM_M = 2
) ();

  logic [NUM_M-1:0]               m_req;
  logic [NUM_M-1:0]               m_we;
  logic [fx_pkg::FX_AW*NUM_M-1:0] m_addr;
  logic [fx_pkg::FX_DW*NUM_M-1:0] m_wdata;
  logic [NUM_M-1:0]               m_ack;
  logic [fx_pkg::FX_DW-1:0]       m_rdata;
  logic [fx_pkg::FX_AW-1:0]       fx_waddr;
  logic                           fx_wr;
  logic [fx_pkg::FX_DW-1:0]       fx_data;
  logic                           fx_rd;
  logic [fx_pkg::FX_AW-1:0]       fx_raddr;
  logic [fx_pkg::FX_DW-1:0]       fx_q;
  logic                           busy;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, fx_q,
    output m_ack, m_rdata, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, busy
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, fx_q,
    input  m_ack, m_rdata, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, busy
  );

endinterface

// File: rtl/fx_bus_arb_rr_pick.sv
// Round-robin pick: first set request searching upward from last+1, wrapping.
module fx_rr_pick #(
  parameter int NUM_M = 2,
  parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    gnt,
  output logic             any_req
);

  localparam int SW = IW + 2;

  logic [2*NUM_M-1:0] dbl;
  logic [NUM_M-1:0]   rot;
  logic [IW-1:0]      enc;
  logic [SW-1:0]      sh;
  logic [SW-1:0]      sum_raw;
  logic [SW-1:0]      sum_wrap;

  // Rotate so last+1 sits at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    sh  = SW'(last) + SW'(1);
    dbl = {req, req} >> sh;
    rot = dbl[NUM_M-1:0];
    enc = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (rot[i]) enc = IW'(i);
    end
    sum_raw  = SW'(enc) + sh;
    sum_wrap = (sum_raw >= SW'(NUM_M)) ? (sum_raw - SW'(NUM_M)) : sum_raw;
    gnt      = sum_wrap[IW-1:0];
    any_req  = |req;
  end

endmodule

// File: rtl/fx_bus_arb.sv
// Round-robin arbiter sharing one fx register bus between NUM_M requesters.
//
// state | meaning
// IDLE  | no transaction; grant the next requester if any m_req is set
// WR    | fx_wr strobe and m_ack to the granted requester, one cycle
// RD    | fx_rd strobe in first cycle, then wait for read latency
// ACK   | m_ack with m_rdata for the granted reader, one cycle
module fx_bus_arb
  import fx_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int RD_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  fx_bus_arb_if.slave bus
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = 3;

  fx_state_e        state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FX_AW-1:0] fx_waddr_q, fx_waddr_d;
  logic [FX_DW-1:0] fx_data_q, fx_data_d;
  logic [FX_AW-1:0] fx_raddr_q, fx_raddr_d;
  logic             fx_wr_q, fx_wr_d;
  logic             fx_rd_q, fx_rd_d;
  logic [NUM_M-1:0] m_ack_q, m_ack_d;
  logic [FX_DW-1:0] m_rdata_q, m_rdata_d;
  logic             busy_q, busy_d;

  logic [IW-1:0]    pick_idx;
  logic             any_req;

  fx_rr_pick #(
    .NUM_M (NUM_M),
    .IW    (IW)
  ) u_pick (
    .req     (bus.m_req),
    .last    (last_q),
    .gnt     (pick_idx),
    .any_req (any_req)
  );

  // Next state and next registered outputs; strobes and ack default low.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    fx_waddr_d = fx_waddr_q;
    fx_data_d  = fx_data_q;
    fx_raddr_d = fx_raddr_q;
    fx_wr_d    = 1'b0;
    fx_rd_d    = 1'b0;
    m_ack_d    = '0;
    m_rdata_d  = m_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d = pick_idx;
          if (bus.m_we[pick_idx]) begin
            state_d    = ST_WR;
            fx_waddr_d = fx_addr_slice((MAX_M*FX_AW)'(bus.m_addr), 32'(pick_idx));
            fx_data_d  = fx_data_slice((MAX_M*FX_DW)'(bus.m_wdata), 32'(pick_idx));
            fx_wr_d    = 1'b1;
            m_ack_d    = NUM_M'(1'b1) << pick_idx;
          end else begin
            state_d    = ST_RD;
            fx_raddr_d = fx_addr_slice((MAX_M*FX_AW)'(bus.m_addr), 32'(pick_idx));
            fx_rd_d    = 1'b1;
            cnt_d      = CW'(RD_LAT);
          end
        end
      end
      ST_WR: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      ST_RD: begin
        cnt_d = cnt_q - CW'(1);
        // Ack lands RD_LAT edges after the fx_rd edge, capturing fx_q there.
        if (cnt_q == CW'(1)) begin
          m_rdata_d = bus.fx_q;
          m_ack_d   = NUM_M'(1'b1) << gnt_q;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears strobes immediately and aborts any transaction.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= IW'(NUM_M - 1);
      gnt_q      <= '0;
      cnt_q      <= '0;
      fx_waddr_q <= '0;
      fx_data_q  <= '0;
      fx_raddr_q <= '0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      m_ack_q    <= '0;
      m_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      fx_waddr_q <= fx_waddr_d;
      fx_data_q  <= fx_data_d;
      fx_raddr_q <= fx_raddr_d;
      fx_wr_q    <= fx_wr_d;
      fx_rd_q    <= fx_rd_d;
      m_ack_q    <= m_ack_d;
      m_rdata_q  <= m_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.fx_waddr = fx_waddr_q;
  assign bus.fx_data  = fx_data_q;
  assign bus.fx_raddr = fx_raddr_q;
  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign bus.m_ack    = m_ack_q;
  assign bus.m_rdata  = m_rdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Scoreboard bench for fx_bus_arb: a 2-requester instance with a read-latency
// slave model and a 4-requester instance for round-robin wrap checks.
module tb_fx_bus_arb;

  typedef struct packed {
    logic [2:0]  m;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  fx_bus_arb_if #(.NUM_M(2)) bus2 ();
  fx_bus_arb_if #(.NUM_M(4)) bus4 ();

  fx_bus_arb #(.NUM_M(2), .RD_LAT(2)) u_dut2 (.clk_sys(clk_sys), .rst(rst), .bus(bus2.slave));
  fx_bus_arb #(.NUM_M(4), .RD_LAT(2)) u_dut4 (.clk_sys(clk_sys), .rst(rst), .bus(bus4.slave));

  always #5 clk_sys = ~clk_sys;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   wr_cyc_last = 0, wr_cyc_prev = 0;
  int   rd_cyc = 0, rd_pulses = 0, ack_cyc2 = 0;
  int   rem2 [2];
  int   rem4 [4];
  exp_t q2 [$];
  exp_t q4 [$];

  function automatic logic [7:0] slv_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7C;
  endfunction

  // fx register slave: data valid only in the cycle after the fx_rd cycle,
  // so it is present at the second edge after fx_rd went high.
  always @(posedge clk_sys or posedge rst) begin
    if (rst)             bus2.fx_q <= 8'h00;
    else if (bus2.fx_rd) bus2.fx_q <= slv_data(bus2.fx_raddr);
    else                 bus2.fx_q <= 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, score acks, retire requests.
  task automatic cycle();
    exp_t e;
    @(negedge clk_sys);
    cyc++;
    chk("excl2", 32'(bus2.fx_wr & bus2.fx_rd), 0);
    chk("excl4", 32'(bus4.fx_wr & bus4.fx_rd), 0);
    if (bus2.fx_wr) begin
      wr_cyc_prev = wr_cyc_last;
      wr_cyc_last = cyc;
    end
    if (bus2.fx_rd) begin
      rd_cyc = cyc;
      rd_pulses++;
    end
    if (bus2.m_ack != 0) begin
      if (q2.size() == 0) chk("ack2_unexpected", 32'(bus2.m_ack), 0);
      else begin
        e = q2.pop_front();
        ack_cyc2 = cyc;
        chk("ack2_vec", 32'(bus2.m_ack), 32'(1) << e.m);
        chk("ack2_wr", 32'(bus2.fx_wr), 32'(e.we));
        if (e.we) begin
          chk("wr2_addr", 32'(bus2.fx_waddr), 32'(e.addr));
          chk("wr2_data", 32'(bus2.fx_data), 32'(e.data));
        end else begin
          chk("rd2_addr", 32'(bus2.fx_raddr), 32'(e.addr));
          chk("rd2_data", 32'(bus2.m_rdata), 32'(e.data));
        end
      end
    end
    if (bus4.m_ack != 0) begin
      if (q4.size() == 0) chk("ack4_unexpected", 32'(bus4.m_ack), 0);
      else begin
        e = q4.pop_front();
        chk("ack4_vec", 32'(bus4.m_ack), 32'(1) << e.m);
        chk("wr4_addr", 32'(bus4.fx_waddr), 32'(e.addr));
        chk("wr4_data", 32'(bus4.fx_data), 32'(e.data));
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (bus2.m_ack[m] && rem2[m] > 0) begin
        rem2[m]--;
        if (rem2[m] == 0) bus2.m_req[m] = 1'b0;
      end
    end
    for (int m = 0; m < 4; m++) begin
      if (bus4.m_ack[m] && rem4[m] > 0) begin
        rem4[m]--;
        if (rem4[m] == 0) bus4.m_req[m] = 1'b0;
      end
    end
  endtask

  task automatic issue2(input int m, input logic we, input logic [15:0] a,
                        input logic [7:0] d, input int n);
    bus2.m_we[m]           = we;
    bus2.m_addr[16*m +: 16] = a;
    bus2.m_wdata[8*m +: 8]  = d;
    rem2[m]                = n;
    bus2.m_req[m]          = 1'b1;
  endtask

  task automatic issue4(input int m, input logic [15:0] a, input logic [7:0] d);
    bus4.m_we[m]            = 1'b1;
    bus4.m_addr[16*m +: 16] = a;
    bus4.m_wdata[8*m +: 8]  = d;
    rem4[m]                 = 1;
    bus4.m_req[m]           = 1'b1;
  endtask

  task automatic exp2(input int m, input logic we, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.m = 3'(m); e.we = we; e.addr = a;
    e.data = we ? d : slv_data(a);
    q2.push_back(e);
  endtask

  task automatic exp4(input int m, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.m = 3'(m); e.we = 1'b1; e.addr = a; e.data = d;
    q4.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q2.size() != 0 || q4.size() != 0 || bus2.m_req != 0 || bus4.m_req != 0 ||
            bus2.busy || bus4.busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 0);
    chk("drain_q2", 32'(q2.size()), 0);
    chk("drain_q4", 32'(q4.size()), 0);
  endtask

  task automatic clear_reqs();
    bus2.m_req = '0;
    bus4.m_req = '0;
    for (int m = 0; m < 2; m++) rem2[m] = 0;
    for (int m = 0; m < 4; m++) rem4[m] = 0;
    q2.delete();
    q4.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    int c0, p0;
    bus2.m_req = '0; bus2.m_we = '0; bus2.m_addr = '0; bus2.m_wdata = '0;
    bus4.m_req = '0; bus4.m_we = '0; bus4.m_addr = '0; bus4.m_wdata = '0;
    bus4.fx_q  = 8'h00;
    for (int m = 0; m < 2; m++) rem2[m] = 0;
    for (int m = 0; m < 4; m++) rem4[m] = 0;

    cycle();
    cycle();
    chk("rst_busy",     32'(bus2.busy), 0);
    chk("rst_fx_wr",    32'(bus2.fx_wr), 0);
    chk("rst_fx_rd",    32'(bus2.fx_rd), 0);
    chk("rst_m_ack",    32'(bus2.m_ack), 0);
    chk("rst_fx_waddr", 32'(bus2.fx_waddr), 0);
    chk("rst_fx_raddr", 32'(bus2.fx_raddr), 0);
    chk("rst_fx_data",  32'(bus2.fx_data), 0);
    chk("rst_m_rdata",  32'(bus2.m_rdata), 0);
    chk("rst_busy4",    32'(bus4.busy), 0);
    rst = 1'b0;
    cycle();

    // Single write from m0
    c0 = cyc;
    issue2(0, 1'b1, 16'h1234, 8'hA5, 1);
    exp2(0, 1'b1, 16'h1234, 8'hA5);
    cycle();
    chk("wr_busy", 32'(bus2.busy), 1);
    drain(20);
    chk("wr_lat", 32'(wr_cyc_last - c0), 1);
    chk("wr_hold_addr", 32'(bus2.fx_waddr), 32'h1234);
    chk("wr_hold_data", 32'(bus2.fx_data), 32'hA5);

    // Single read from m1
    c0 = cyc;
    p0 = rd_pulses;
    issue2(1, 1'b0, 16'h0040, 8'h00, 1);
    exp2(1, 1'b0, 16'h0040, 8'h00);
    drain(20);
    chk("rd_pulses", 32'(rd_pulses - p0), 1);
    chk("rd_lat", 32'(ack_cyc2 - c0), 3);
    chk("rd_to_ack", 32'(ack_cyc2 - rd_cyc), 2);
    chk("rd_hold_raddr", 32'(bus2.fx_raddr), 32'h0040);
    chk("rd_hold_rdata", 32'(bus2.m_rdata), 32'h3C);

    // Contention after reset: m0 first, then strict alternation over 8 transactions
    do_reset();
    issue2(0, 1'b1, 16'h1000, 8'h11, 4);
    issue2(1, 1'b0, 16'h0155, 8'h00, 4);
    for (int k = 0; k < 4; k++) begin
      exp2(0, 1'b1, 16'h1000, 8'h11);
      exp2(1, 1'b0, 16'h0155, 8'h00);
    end
    drain(100);

    // Back-to-back: m0 holds request one extra cycle
    issue2(0, 1'b1, 16'hBEEF, 8'h5A, 2);
    exp2(0, 1'b1, 16'hBEEF, 8'h5A);
    exp2(0, 1'b1, 16'hBEEF, 8'h5A);
    drain(20);
    chk("b2b_gap", 32'(wr_cyc_last - wr_cyc_prev), 2);

    // Reset while a read from m1 waits with cnt=1 (last is 0 before reset)
    issue2(1, 1'b0, 16'h0081, 8'h00, 1);
    cycle();
    chk("abort_rd_strobe", 32'(bus2.fx_rd), 1);
    cycle();
    rst = 1'b1;
    #1;
    chk("abort_busy",     32'(bus2.busy), 0);
    chk("abort_fx_rd",    32'(bus2.fx_rd), 0);
    chk("abort_fx_raddr", 32'(bus2.fx_raddr), 0);
    chk("abort_fx_waddr", 32'(bus2.fx_waddr), 0);
    chk("abort_fx_data",  32'(bus2.fx_data), 0);
    chk("abort_m_rdata",  32'(bus2.m_rdata), 0);
    chk("abort_m_ack",    32'(bus2.m_ack), 0);
    clear_reqs();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
    issue2(0, 1'b1, 16'h0A0A, 8'h0A, 1);
    issue2(1, 1'b1, 16'h0B0B, 8'h0B, 1);
    exp2(0, 1'b1, 16'h0A0A, 8'h0A);
    exp2(1, 1'b1, 16'h0B0B, 8'h0B);
    drain(30);

    // Wrap-around on the 4-requester instance
    issue4(3, 16'h0300, 8'h33);
    exp4(3, 16'h0300, 8'h33);
    drain(20);
    issue4(1, 16'h0101, 8'h01);
    issue4(3, 16'h0303, 8'h03);
    exp4(1, 16'h0101, 8'h01);
    exp4(3, 16'h0303, 8'h03);
    drain(30);
    issue4(1, 16'h0111, 8'h71);
    exp4(1, 16'h0111, 8'h71);
    drain(20);
    issue4(0, 16'h0000, 8'h40);
    issue4(3, 16'h0333, 8'h43);
    exp4(3, 16'h0333, 8'h43);
    exp4(0, 16'h0000, 8'h40);
    drain(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fx_bus_arb.md
Name: fx_bus_arb

Overview:
- Shares the slave's single fx register bus between NUM_M requesters, for example the 485 control path and a local sequencer.
- The fx bus carries a 16-bit write/read address, 8-bit write data and an 8-bit read return.
- The block accepts one transaction per requester at a time, grants round-robin, drives the fx bus strobes, and returns an ack with read data at fixed read latency.
- It sits between the requesters and the fx register slaves, in place of a direct control-path-to-bus connection.

Parameters:
- NUM_M, 2, number of requesters (2..8).
- RD_LAT, 2, cycles from the fx_rd strobe cycle to valid fx_q (1..7).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  NUM_M  per-requester request; held until that requester's ack.
- m_we  in  NUM_M  per-requester 1=write, 0=read; stable while m_req is high.
- m_addr  in  16*NUM_M  per-requester address; slice m = [16m+15:16m].
- m_wdata  in  8*NUM_M  per-requester write data; slice m = [8m+7:8m].
- m_ack  out  NUM_M  one-cycle completion pulse to the granted requester.
- m_rdata  out  8  read data; valid in the m_ack cycle of a read.
- fx_waddr  out  16  write address to the fx bus.
- fx_wr  out  1  one-cycle write strobe.
- fx_data  out  8  write data.
- fx_rd  out  1  one-cycle read strobe.
- fx_raddr  out  16  read address; held from the fx_rd cycle until ack.
- fx_q  in  8  read data from the fx bus.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; round-robin pointer last = NUM_M-1, so master 0 has highest priority first.
  - All outputs are 0: fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, m_ack, m_rdata, busy.
  - Reset mid-transaction aborts it without an ack. The strobe drops immediately (asynchronously).
- All outputs are registered.
- FSM states:
  - IDLE
    - No m_req bit set: stay in IDLE.
    - Otherwise grant g = first set bit searching from (last+1) mod NUM_M upward, wrapping; latch g.
    - m_we[g]=1: next state WR. Load fx_waddr/fx_data from slice g, fx_wr=1, m_ack[g]=1.
    - m_we[g]=0: next state RD. Load fx_raddr from slice g, fx_rd=1, cnt=RD_LAT.
  - WR
    - Lasts 1 cycle with fx_wr and m_ack[g] high.
    - Next: fx_wr=0, m_ack=0, last=g, go to IDLE.
  - RD
    - fx_rd is high only in the first RD cycle. cnt decrements each cycle.
    - When cnt reaches 1: m_rdata <= fx_q, m_ack[g] <= 1, go to ACK.
    - Result: m_ack is high exactly RD_LAT cycles after the fx_rd cycle, carrying fx_q as sampled RD_LAT cycles after fx_rd.
  - ACK
    - 1 cycle; m_ack drops after it.
    - last=g, go to IDLE.
- Latency:
  - Write: fx_wr and ack one cycle after m_req is first seen in IDLE.
  - Read: ack at RD_LAT+1 cycles after req.
- Throughput: at least 1 idle cycle between transactions, so a write is at most 1 per 2 cycles.
- The requester must drop m_req on the edge after it sees m_ack. If m_req is still high when IDLE samples it, that is a new transaction.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - Requesters that lose the grant keep waiting; no request is dropped.
- Fairness: with all NUM_M requesting continuously, each requester is served once per NUM_M transactions.
- fx_waddr/fx_data hold their last values after a write. fx_raddr holds until the next read is granted.
- m_rdata holds its value until the next read ack.
- Bus exclusivity: fx_wr and fx_rd are never high in the same cycle.
- Requests whose m_req drops before grant are ignored. A requester that drops m_req after grant still receives an ack.

Decomposition:
- Package fx_pkg:
  - FX_AW=16, FX_DW=8.
  - FSM state enum {IDLE, WR, RD, ACK}.
  - Helper function for slice extraction.
- One sub-module, fx_rr_pick (combinational):
  - Inputs: req vector, last pointer.
  - Outputs: grant index and any_req.
  - Implements the rotate, priority-encode and unrotate search.

Test Plan:
- Single write: m0 write addr 0x1234, data 0xA5 → one cycle later fx_wr=1, fx_waddr=0x1234, fx_data=0xA5, m_ack=01 for exactly 1 cycle; fx_rd stays 0.
- Single read, RD_LAT=2: m1 read addr 0x0040; slave model returns 0x3C two cycles after fx_rd → fx_rd=1 for 1 cycle, fx_raddr=0x0040 held, m_ack=10 at fx_rd+2 with m_rdata=0x3C.
- Contention: m0 and m1 both request in the same cycle after reset → m0 is served first, then m1. Continuous requests alternate 0,1,0,1 over 8 transactions, with no strobe overlap.
- Wrap-around, NUM_M=4: after a grant to m3, with requests on m1 and m3 → m1 is granted next.
- Reset mid-read: assert rst during RD with cnt=1 → all outputs are 0 at once, no m_ack, and the FSM is in IDLE with last=NUM_M-1 after release.
- Back-to-back: m0 holds m_req one extra cycle after ack → a second identical write is issued 2 cycles after the first fx_wr.
